// File: rtl/z_pattern_tracker_if.sv
// Symbol-in / match-event-out bundle for z_pattern_tracker.
// The master drives symbols and consumes events; the slave is the tracker.
interface z_pattern_tracker_if #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             z1;
  logic             z2;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] match_count;
  logic             sat;
  logic [RUN_W-1:0] run_len;

  modport master (
    output in_valid, z1, z2, out_ready,
    input  in_ready, out_valid, out_count, match_count, sat, run_len
  );

  modport slave (
    input  in_valid, z1, z2, out_ready,
    output in_ready, out_valid, out_count, match_count, sat, run_len
  );
endinterface

// File: rtl/z_pattern_tracker.sv
// z_pattern_tracker: watches the decoder's (Z1,Z2) symbol stream for the
// sequence 10 -> 00 -> 11, counts matches (saturating), tracks the length of
// the current run of identical symbols and emits one event per match on a
// valid/ready port. A pending event stalls the input so no event is lost.
module z_pattern_tracker #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  z_pattern_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_A  = 2'd1,
    GOT_AB = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_sym_q, last_sym_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic [1:0]       sym;
  logic             in_ready;
  logic             accept;
  logic             match;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + RUN_W'(1);
  endfunction

  assign sym      = {bus.z1, bus.z2};
  // Only a pending, unconsumed event can stall the input.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Next-state: pattern FSM, run length, match counter and event register.
  always_comb begin
    state_d     = state_q;
    last_sym_d  = last_sym_q;
    run_len_d   = run_len_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    match       = 1'b0;

    if (clr) begin
      state_d     = IDLE;
      last_sym_d  = 2'b00;
      run_len_d   = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      out_count_d = '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end

      if (accept) begin
        unique case (state_q)
          IDLE:    state_d = (sym == 2'b10) ? GOT_A : IDLE;
          GOT_A: begin
            if (sym == 2'b00)      state_d = GOT_AB;
            else if (sym == 2'b10) state_d = GOT_A;
            else                   state_d = IDLE;
          end
          GOT_AB: begin
            if (sym == 2'b11) begin
              state_d = IDLE;
              match   = 1'b1;
            end else if (sym == 2'b10) begin
              state_d = GOT_A;
            end else begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase

        // run_len==0 only right after reset/clear, where the first symbol starts a run.
        if ((sym == last_sym_q) && (run_len_q != '0)) begin
          run_len_d = sat_inc_run(run_len_q);
        end else begin
          run_len_d = RUN_W'(1);
        end
        last_sym_d = sym;
      end

      // A match overrides the drain so the new event is always presented.
      if (match) begin
        cnt_d       = sat_inc_cnt(cnt_q);
        sat_d       = sat_q || (cnt_q == '1);
        out_valid_d = 1'b1;
        out_count_d = cnt_d;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_sym_q  <= 2'b00;
      run_len_q   <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      last_sym_q  <= last_sym_d;
      run_len_q   <= run_len_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_count   = out_count_q;
  assign bus.match_count = cnt_q;
  assign bus.sat         = sat_q;
  assign bus.run_len     = run_len_q;

endmodule

// File: tb/tb_z_pattern_tracker.sv
// Directed bench for z_pattern_tracker with CNT_W=2 so counter saturation is
// reachable in a few matches. Observed vector per check:
// {in_ready, out_valid, out_count[1:0], match_count[1:0], sat, run_len[3:0]}.
module tb_z_pattern_tracker;
  localparam int CNT_W = 2;
  localparam int RUN_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  z_pattern_tracker_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) bus ();

  z_pattern_tracker #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic        ordy;
    logic        c;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [10:0] pk(input logic ir, input logic ov, input logic [1:0] oc,
                                     input logic [1:0] mc, input logic st, input logic [3:0] rl);
    return {ir, ov, oc, mc, st, rl};
  endfunction

  function automatic string fmt(input logic [10:0] x);
    return $sformatf("ir=%b ov=%b oc=%0d mc=%0d sat=%b rl=%0d",
                     x[10], x[9], x[8:7], x[6:5], x[4], x[3:0]);
  endfunction

  function automatic logic [10:0] observed();
    return {bus.in_ready, bus.out_valid, bus.out_count, bus.match_count, bus.sat, bus.run_len};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(exp));
  endtask

  task automatic row(input string nm, input logic v, input logic [1:0] s, input logic ordy,
                     input logic c, input logic ir, input logic ov, input logic [1:0] oc,
                     input logic [1:0] mc, input logic st, input logic [3:0] rl);
    vec_t r;
    r.v = v; r.s = s; r.ordy = ordy; r.c = c;
    r.exp = pk(ir, ov, oc, mc, st, rl);
    r.name = nm;
    vq.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic ordy, input logic c);
    bus.in_valid  = v;
    bus.z1        = s[1];
    bus.z2        = s[0];
    bus.out_ready = ordy;
    clr           = c;
  endtask

  task automatic step(input string nm, input logic v, input logic [1:0] s, input logic ordy,
                      input logic c, input logic [10:0] exp);
    drive(v, s, ordy, c);
    @(posedge clk);
    #1;
    check(nm, observed(), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int p, c;

    // Idle after reset
    for (int i = 0; i < 5; i++) row("idle", 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
    // Basic match 10,00,11 then event drains
    row("basic_10", 1, 2'b10, 1, 0, 1, 0, 0, 0, 0, 1);
    row("basic_00", 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1);
    row("basic_11", 1, 2'b11, 1, 0, 1, 1, 1, 1, 0, 1);
    row("basic_drain", 0, 2'b00, 1, 0, 1, 0, 1, 1, 0, 1);
    // 10,10,00,11 -> match
    row("rep_10a", 1, 2'b10, 1, 0, 1, 0, 1, 1, 0, 1);
    row("rep_10b", 1, 2'b10, 1, 0, 1, 0, 1, 1, 0, 2);
    row("rep_00",  1, 2'b00, 1, 0, 1, 0, 1, 1, 0, 1);
    row("rep_11",  1, 2'b11, 1, 0, 1, 1, 2, 2, 0, 1);
    // 10,00,10,00,11 -> match
    row("re_10a", 1, 2'b10, 1, 0, 1, 0, 2, 2, 0, 1);
    row("re_00a", 1, 2'b00, 1, 0, 1, 0, 2, 2, 0, 1);
    row("re_10b", 1, 2'b10, 1, 0, 1, 0, 2, 2, 0, 1);
    row("re_00b", 1, 2'b00, 1, 0, 1, 0, 2, 2, 0, 1);
    row("re_11",  1, 2'b11, 1, 0, 1, 1, 3, 3, 0, 1);
    // 10,00,01,11 -> no match
    row("nm_10", 1, 2'b10, 1, 0, 1, 0, 3, 3, 0, 1);
    row("nm_00", 1, 2'b00, 1, 0, 1, 0, 3, 3, 0, 1);
    row("nm_01", 1, 2'b01, 1, 0, 1, 0, 3, 3, 0, 1);
    row("nm_11", 1, 2'b11, 1, 0, 1, 0, 3, 3, 0, 1);
    // Run of 10s
    row("run_1", 1, 2'b10, 1, 0, 1, 0, 3, 3, 0, 1);
    row("run_2", 1, 2'b10, 1, 0, 1, 0, 3, 3, 0, 2);
    row("run_3", 1, 2'b10, 1, 0, 1, 0, 3, 3, 0, 3);
    // clr discards the offered symbol
    row("clr_a", 1, 2'b10, 1, 1, 1, 0, 0, 0, 0, 0);
    // Backpressure: event pending with out_ready=0 stalls input
    row("bp_10", 1, 2'b10, 1, 0, 1, 0, 0, 0, 0, 1);
    row("bp_00", 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1);
    row("bp_11", 1, 2'b11, 0, 0, 0, 1, 1, 1, 0, 1);
    row("bp_hold1", 1, 2'b11, 0, 0, 0, 1, 1, 1, 0, 1);
    row("bp_hold2", 1, 2'b11, 0, 0, 0, 1, 1, 1, 0, 1);
    row("bp_release", 1, 2'b11, 1, 0, 1, 0, 1, 1, 0, 2);
    // Counter saturation
    row("clr_b", 0, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      p = (k - 1 > 3) ? 3 : k - 1;
      c = (k > 3) ? 3 : k;
      row($sformatf("sat%0d_10", k), 1, 2'b10, 1, 0, 1, 0, 2'(p), 2'(p), 0, 1);
      row($sformatf("sat%0d_00", k), 1, 2'b00, 1, 0, 1, 0, 2'(p), 2'(p), 0, 1);
      row($sformatf("sat%0d_11", k), 1, 2'b11, 1, 0, 1, 1, 2'(c), 2'(c), (k == 4), 1);
    end
    row("sat_drain", 0, 2'b00, 1, 0, 1, 0, 3, 3, 1, 1);
    row("clr_c", 0, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0);
    // Run-length saturation at 15
    for (int i = 1; i <= 16; i++)
      row($sformatf("runsat_%0d", i), 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 4'((i > 15) ? 15 : i));

    // Reset state, checked while reset is held
    drive(0, 2'b00, 1, 0);
    #2;
    check("reset_state", observed(), pk(1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vq[i]) step(vq[i].name, vq[i].v, vq[i].s, vq[i].ordy, vq[i].c, vq[i].exp);

    // Asynchronous reset mid-pattern
    step("ar_10", 1, 2'b10, 1, 0, pk(1, 0, 0, 0, 0, 1));
    step("ar_00", 1, 2'b00, 1, 0, pk(1, 0, 0, 0, 0, 1));
    step("ar_11", 1, 2'b11, 1, 0, pk(1, 1, 1, 1, 0, 1));
    step("ar_10b", 1, 2'b10, 1, 0, pk(1, 0, 1, 1, 0, 1));
    step("ar_00b", 1, 2'b00, 1, 0, pk(1, 0, 1, 1, 0, 1));
    drive(0, 2'b00, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_immediate", observed(), pk(1, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b1;
    step("ar_lone_11", 1, 2'b11, 1, 0, pk(1, 0, 0, 0, 0, 1));

    // clr with a pending, unconsumed event: in_ready still reflects backpressure
    step("cr_10", 1, 2'b10, 1, 0, pk(1, 0, 0, 0, 0, 1));
    step("cr_00", 1, 2'b00, 1, 0, pk(1, 0, 0, 0, 0, 1));
    step("cr_11", 1, 2'b11, 0, 0, pk(0, 1, 1, 1, 0, 1));
    drive(1, 2'b10, 0, 1);
    #1;
    n_total++;
    if (bus.in_ready === 1'b0) n_pass++;
    else $display("FAIL clr_in_ready: got %b, expected 0", bus.in_ready);
    @(posedge clk);
    #1;
    check("cr_cleared", observed(), pk(1, 0, 0, 0, 0, 0));
    step("cr_after", 0, 2'b00, 1, 0, pk(1, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
